// File: rtl/stat_readout_ctrl.sv
// rtl/stat_readout_ctrl.sv - statistics snapshot controller: halt freeze, host handshake, readout and display scan
module stat_readout_ctrl #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt,
    input  logic [31:0] j_cnt,
    input  logic [31:0] r_cnt,
    input  logic [31:0] i_cnt,
    input  logic [31:0] cyc_cnt,
    output logic        cnt_en,
    output logic        halted,
    input  logic        snap_req,
    output logic        snap_ack,
    input  logic        rd_req,
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [1:0]  disp_sel,
    output logic [31:0] disp_val
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state;
    logic             halted_q;
    logic             auto_cap;
    logic             cap_en;
    logic [31:0]      snap [4];
    logic [DIV_W-1:0] div_cnt;

    assign cnt_en   = run & ~halted;
    // halted_q lags halted by one edge, so auto_cap is a single-cycle pulse per halt
    assign auto_cap = halted & ~halted_q;
    assign cap_en   = (state == S_CAPT) | auto_cap;
    assign disp_val = snap[disp_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            if (halt)
                halted <= 1'b1;
            halted_q <= halted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            snap_ack <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (snap_req)
                        state <= S_CAPT;
                    snap_ack <= 1'b0;
                end
                S_CAPT: begin
                    state    <= S_ACK;
                    snap_ack <= 1'b1;
                end
                S_ACK: begin
                    if (!snap_req) begin
                        state    <= S_IDLE;
                        snap_ack <= 1'b0;
                    end else begin
                        snap_ack <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    snap_ack <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++)
                snap[k] <= 32'd0;
        end else if (cap_en) begin
            snap[0] <= j_cnt;
            snap[1] <= r_cnt;
            snap[2] <= i_cnt;
            snap[3] <= cyc_cnt;
        end
    end

    // Non-blocking read of snap returns the pre-capture value on a collision edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 32'd0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req)
                rd_data <= snap[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            disp_sel <= 2'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            disp_sel <= disp_sel + 2'd1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stat_readout_ctrl.sv
// tb/tb_stat_readout_ctrl.sv - directed self-checking bench for stat_readout_ctrl
module tb_stat_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        halt;
    logic [31:0] j_cnt, r_cnt, i_cnt, cyc_cnt;
    logic        cnt_en, halted;
    logic        snap_req, snap_ack;
    logic        rd_req;
    logic [1:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [1:0]  disp_sel;
    logic [31:0] disp_val;

    int checks = 0;
    int errors = 0;
    bit count_mode = 1'b0;

    stat_readout_ctrl #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .j_cnt(j_cnt), .r_cnt(r_cnt), .i_cnt(i_cnt), .cyc_cnt(cyc_cnt),
        .cnt_en(cnt_en), .halted(halted),
        .snap_req(snap_req), .snap_ack(snap_ack),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .disp_sel(disp_sel), .disp_val(disp_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] j, r, i, c;
        logic [1:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; in count_mode the bench models the external cycle counter
    task automatic tick();
        logic en;
        en = cnt_en;
        @(posedge clk);
        #1;
        if (count_mode && en)
            cyc_cnt = cyc_cnt + 32'd1;
    endtask

    task automatic set_cnts(input logic [31:0] j, input logic [31:0] r, input logic [31:0] i, input logic [31:0] c);
        j_cnt = j; r_cnt = r; i_cnt = i; cyc_cnt = c;
    endtask

    task automatic do_read(input logic [1:0] idx, input logic [31:0] exp, input string name);
        rd_req = 1'b1;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
        chk({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk(name, rd_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] scan_snap [4];
    logic [31:0] exp_val;
    int waited;

    initial begin
        vecs[0] = '{j: 32'd3, r: 32'd5, i: 32'd7, c: 32'd20, idx: 2'd0, exp: 32'd3};
        vecs[1] = '{j: 32'd3, r: 32'd5, i: 32'd7, c: 32'd20, idx: 2'd1, exp: 32'd5};
        vecs[2] = '{j: 32'd3, r: 32'd5, i: 32'd7, c: 32'd20, idx: 2'd2, exp: 32'd7};
        vecs[3] = '{j: 32'd3, r: 32'd5, i: 32'd7, c: 32'd20, idx: 2'd3, exp: 32'd20};
        vecs[4] = '{j: 32'hFFFF_FFFF, r: 32'h0, i: 32'hA5A5_5A5A, c: 32'h8000_0001, idx: 2'd2, exp: 32'hA5A5_5A5A};

        rst = 1'b1; run = 1'b0; halt = 1'b0; snap_req = 1'b0;
        rd_req = 1'b0; rd_idx = 2'd0;
        set_cnts(32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("rst_ack", {31'd0, snap_ack}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_disp_sel", {30'd0, disp_sel}, 32'd0);
        chk("rst_disp_val", disp_val, 32'd0);
        tick();
        rst = 1'b0;
        run = 1'b1;
        #1;
        chk("cnt_en_follows_run", {31'd0, cnt_en}, 32'd1);
        run = 1'b0;

        // Table-driven handshake + read vectors
        for (int v = 0; v < 5; v++) begin
            set_cnts(vecs[v].j, vecs[v].r, vecs[v].i, vecs[v].c);
            snap_req = 1'b1;
            tick();
            chk("hs_ack_edge1", {31'd0, snap_ack}, 32'd0);
            tick();
            chk("hs_ack_edge2", {31'd0, snap_ack}, 32'd1);
            set_cnts(32'd111, 32'd222, 32'd333, 32'd444);
            do_read(vecs[v].idx, vecs[v].exp, "hs_read");
            chk("hs_ack_held", {31'd0, snap_ack}, 32'd1);
            snap_req = 1'b0;
            tick();
            chk("hs_ack_drop", {31'd0, snap_ack}, 32'd0);
            tick();
        end

        // Read/capture collision: snap[1]=5 from the last table entry set? reload explicitly
        set_cnts(32'd0, 32'd5, 32'd0, 32'd0);
        snap_req = 1'b1; tick(); tick(); snap_req = 1'b0; tick();
        r_cnt = 32'd9;
        snap_req = 1'b1;
        tick();
        rd_req = 1'b1; rd_idx = 2'd1;
        tick();
        rd_req = 1'b0;
        chk("coll_pre_capture", rd_data, 32'd5);
        chk("coll_ack", {31'd0, snap_ack}, 32'd1);
        do_read(2'd1, 32'd9, "coll_post_capture");
        rd_req = 1'b1; rd_idx = 2'd0; tick();
        rd_idx = 2'd1; tick();
        rd_req = 1'b0;
        chk("b2b_valid", {31'd0, rd_valid}, 32'd1);
        chk("b2b_data", rd_data, 32'd9);
        tick();
        chk("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
        chk("rd_data_hold", rd_data, 32'd9);
        snap_req = 1'b0; tick();

        // Scan with SCAN_DIV=4 from a fresh reset; capture at edge 2
        do_reset();
        set_cnts(32'd11, 32'd22, 32'd33, 32'd44);
        scan_snap[0] = 32'd11; scan_snap[1] = 32'd22; scan_snap[2] = 32'd33; scan_snap[3] = 32'd44;
        snap_req = 1'b1;
        chk("scan_sel_0", {30'd0, disp_sel}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) snap_req = 1'b0;
            chk("scan_sel", {30'd0, disp_sel}, (k / 4) % 4);
            exp_val = (k < 2) ? 32'd0 : scan_snap[(k / 4) % 4];
            chk("scan_val", disp_val, exp_val);
        end

        // Halt freeze with modelled cycle counter
        set_cnts(32'd0, 32'd0, 32'd0, 32'd38);
        run = 1'b1;
        count_mode = 1'b1;
        waited = 0;
        while (cyc_cnt != 32'd41 && waited < 20) begin
            tick();
            waited++;
        end
        chk("halt_reach_41", cyc_cnt, 32'd41);
        chk("halt_cnt_en_pre", {31'd0, cnt_en}, 32'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_set", {31'd0, halted}, 32'd1);
        chk("halt_cnt_en_off", {31'd0, cnt_en}, 32'd0);
        tick();
        chk("halt_frozen", cyc_cnt, 32'd42);
        do_read(2'd3, 32'd42, "halt_read");
        count_mode = 1'b0;
        cyc_cnt = 32'd99;
        tick(); tick();
        do_read(2'd3, 32'd42, "halt_once");
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        // Reset in ACK with snap_req held
        run = 1'b0;
        do_reset();
        set_cnts(32'd1, 32'd2, 32'd3, 32'd4);
        snap_req = 1'b1;
        tick(); tick();
        chk("ra_ack_pre", {31'd0, snap_ack}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ra_ack_rst", {31'd0, snap_ack}, 32'd0);
        chk("ra_halted_rst", {31'd0, halted}, 32'd0);
        chk("ra_disp_val_rst", disp_val, 32'd0);
        chk("ra_rd_data_rst", rd_data, 32'd0);
        tick();
        rst = 1'b0;
        set_cnts(32'd6, 32'd7, 32'd8, 32'd9);
        rd_req = 1'b1; rd_idx = 2'd2;
        tick();
        rd_req = 1'b0;
        chk("ra_snap_cleared", rd_data, 32'd0);
        chk("ra_ack_edge1", {31'd0, snap_ack}, 32'd0);
        tick();
        chk("ra_ack_edge2", {31'd0, snap_ack}, 32'd1);
        do_read(2'd2, 32'd8, "ra_new_capture");

        // Halt during ACK overwrites snapshot, ack holds
        set_cnts(32'd50, 32'd51, 32'd52, 32'd53);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        chk("hack_ack_held", {31'd0, snap_ack}, 32'd1);
        do_read(2'd0, 32'd50, "hack_read");
        chk("hack_ack_held2", {31'd0, snap_ack}, 32'd1);
        snap_req = 1'b0;
        tick();
        chk("hack_ack_drop", {31'd0, snap_ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
